// File: rtl/serial_input_receiver.sv
// Serial-to-parallel front end: deserialises framed MSB-first left/right streams,
// paces the word-ready handshake and tracks per-channel zero-word runs.
module serial_input_receiver #(
  parameter int WORD_W      = 16,
  parameter int ZERO_THRESH = 800,
  parameter int RDY_CYCLES  = 8
) (
  input  logic              Dclk,
  input  logic              Clear,
  input  logic              Frame,
  input  logic              InputL,
  input  logic              InputR,
  input  logic              InReady,
  input  logic              zero_det_en,
  output logic [WORD_W-1:0] data_L,
  output logic [WORD_W-1:0] data_R,
  output logic              input_rdy_flag,
  output logic              zero_flag_L,
  output logic              zero_flag_R,
  output logic              frame_err
);

  localparam int BC_W = $clog2(WORD_W);
  localparam int ZC_W = $clog2(ZERO_THRESH + 1);
  localparam int RC_W = $clog2(RDY_CYCLES);

  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_SHIFT  = 1'b1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [ZC_W-1:0] ZTH      = ZC_W'(ZERO_THRESH);
  localparam logic [RC_W-1:0] RDY_LOAD = RC_W'(RDY_CYCLES - 1);

  logic [0:0]        r_state;
  logic [BC_W-1:0]   r_bitcnt;
  logic [WORD_W-2:0] r_shl;
  logic [WORD_W-2:0] r_shr;
  logic [ZC_W-1:0]   r_zcnt_l;
  logic [ZC_W-1:0]   r_zcnt_r;
  logic [RC_W-1:0]   r_rdycnt;

  logic [WORD_W-1:0] w_word_l;
  logic [WORD_W-1:0] w_word_r;
  logic              w_done;
  logic              w_ferr;
  logic [ZC_W-1:0]   w_zinc_l;
  logic [ZC_W-1:0]   w_zinc_r;

  function automatic logic [ZC_W-1:0] sat_inc(input logic [ZC_W-1:0] v);
    return (v >= ZTH) ? ZTH : v + ZC_W'(1);
  endfunction

  // The incoming bit is appended so the full word is visible on the completion edge.
  assign w_word_l = {r_shl, InputL};
  assign w_word_r = {r_shr, InputR};
  assign w_ferr   = (r_state == S_SHIFT) && Frame;
  assign w_done   = (r_state == S_SHIFT) && !Frame && (r_bitcnt == LAST_BIT);
  assign w_zinc_l = sat_inc(r_zcnt_l);
  assign w_zinc_r = sat_inc(r_zcnt_r);

  always_ff @(posedge Dclk) begin
    if (Clear) begin
      r_state        <= S_IDLE;
      r_bitcnt       <= '0;
      r_shl          <= '0;
      r_shr          <= '0;
      data_L         <= '0;
      data_R         <= '0;
      frame_err      <= 1'b0;
    end else begin
      frame_err <= w_ferr;
      case (r_state)
        S_IDLE: begin
          if (Frame && InReady) begin
            r_shl    <= (WORD_W-1)'(InputL);
            r_shr    <= (WORD_W-1)'(InputR);
            r_bitcnt <= BC_W'(1);
            r_state  <= S_SHIFT;
          end
        end
        default: begin
          if (Frame) begin
            // Resynchronise on the new frame; partial word is dropped.
            r_shl    <= (WORD_W-1)'(InputL);
            r_shr    <= (WORD_W-1)'(InputR);
            r_bitcnt <= InReady ? BC_W'(1) : '0;
            r_state  <= InReady ? S_SHIFT : S_IDLE;
          end else if (w_done) begin
            data_L   <= w_word_l;
            data_R   <= w_word_r;
            r_bitcnt <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_shl    <= w_word_l[WORD_W-2:0];
            r_shr    <= w_word_r[WORD_W-2:0];
            r_bitcnt <= r_bitcnt + BC_W'(1);
          end
        end
      endcase
    end
  end

  // Ready pulse has a fixed width independent of framing activity.
  always_ff @(posedge Dclk) begin
    if (Clear) begin
      r_rdycnt       <= '0;
      input_rdy_flag <= 1'b0;
    end else if (w_done) begin
      r_rdycnt       <= RDY_LOAD;
      input_rdy_flag <= 1'b1;
    end else if (r_rdycnt != '0) begin
      r_rdycnt       <= r_rdycnt - RC_W'(1);
    end else begin
      input_rdy_flag <= 1'b0;
    end
  end

  always_ff @(posedge Dclk) begin
    if (Clear || !zero_det_en) begin
      r_zcnt_l    <= '0;
      r_zcnt_r    <= '0;
      zero_flag_L <= 1'b0;
      zero_flag_R <= 1'b0;
    end else if (w_done) begin
      r_zcnt_l    <= (w_word_l == '0) ? w_zinc_l : '0;
      zero_flag_L <= (w_word_l == '0) && (w_zinc_l == ZTH);
      r_zcnt_r    <= (w_word_r == '0) ? w_zinc_r : '0;
      zero_flag_R <= (w_word_r == '0) && (w_zinc_r == ZTH);
    end
  end

endmodule

// File: tb/tb_serial_input_receiver.sv
// Scoreboard bench for serial_input_receiver: words are queued as they are sent
// and checked by a monitor on each rising edge of input_rdy_flag.
module tb_serial_input_receiver;

  logic        Dclk = 1'b0;
  logic        Clear, Frame, InputL, InputR, InReady, zero_det_en;
  logic [15:0] data_L, data_R;
  logic        input_rdy_flag, zero_flag_L, zero_flag_R, frame_err;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        zl;
    logic        zr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   rdy_w = 0;
  int   ferr_cnt = 0;
  logic prev_rdy = 1'b0;
  logic prev_ferr = 1'b0;

  serial_input_receiver #(.WORD_W(16), .ZERO_THRESH(800), .RDY_CYCLES(8)) dut (
    .Dclk(Dclk), .Clear(Clear), .Frame(Frame), .InputL(InputL), .InputR(InputR),
    .InReady(InReady), .zero_det_en(zero_det_en), .data_L(data_L), .data_R(data_R),
    .input_rdy_flag(input_rdy_flag), .zero_flag_L(zero_flag_L),
    .zero_flag_R(zero_flag_R), .frame_err(frame_err)
  );

  always #5 Dclk = ~Dclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each newly presented word against the scoreboard.
  always @(negedge Dclk) begin
    if (input_rdy_flag === 1'b1 && prev_rdy === 1'b0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got L=%h R=%h expected none", data_L, data_R);
      end else begin
        e = q.pop_front();
        chk("data_L", {16'h0, data_L}, {16'h0, e.l});
        chk("data_R", {16'h0, data_R}, {16'h0, e.r});
        chk("zero_flag_L", {31'h0, zero_flag_L}, {31'h0, e.zl});
        chk("zero_flag_R", {31'h0, zero_flag_R}, {31'h0, e.zr});
      end
    end
    if (input_rdy_flag === 1'b1) rdy_w++;
    else begin
      if (prev_rdy === 1'b1) chk("rdy_width", rdy_w, 8);
      rdy_w = 0;
    end
    if (frame_err === 1'b1) begin
      chk("frame_err_width", {31'h0, prev_ferr}, 32'h0);
      ferr_cnt++;
    end
    prev_rdy  = input_rdy_flag;
    prev_ferr = frame_err;
  end

  task automatic drive(input logic [15:0] l, input logic [15:0] r, input int i);
    @(negedge Dclk);
    Frame  = (i == 0);
    InputL = l[15-i];
    InputR = r[15-i];
  endtask

  task automatic send_word(input logic [15:0] l, input logic [15:0] r, input bit push,
                           input logic zl, input logic zr, input int drop_at);
    if (push) q.push_back('{l: l, r: r, zl: zl, zr: zr});
    for (int i = 0; i < 16; i++) begin
      drive(l, r, i);
      if (i == drop_at) InReady = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Dclk);
      Frame  = 1'b0;
      InputL = 1'b0;
      InputR = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_L"}, {16'h0, data_L}, 32'h0);
    chk({tag, "_data_R"}, {16'h0, data_R}, 32'h0);
    chk({tag, "_rdy"}, {31'h0, input_rdy_flag}, 32'h0);
    chk({tag, "_zfl"}, {31'h0, zero_flag_L}, 32'h0);
    chk({tag, "_zfr"}, {31'h0, zero_flag_R}, 32'h0);
    chk({tag, "_ferr"}, {31'h0, frame_err}, 32'h0);
  endtask

  logic [15:0] b2b [4] = '{16'h0001, 16'h0002, 16'h8000, 16'hFFFF};

  initial begin
    Clear = 1'b1; Frame = 1'b0; InputL = 1'b0; InputR = 1'b0;
    InReady = 1'b1; zero_det_en = 1'b0;
    repeat (3) @(negedge Dclk);
    chk_all_zero("reset");
    Clear = 1'b0;

    // Single word
    send_word(16'hA5C3, 16'h0001, 1, 0, 0, -1);
    idle(20);
    chk("single_no_ferr", ferr_cnt, 0);

    // Back-to-back words
    for (int k = 0; k < 4; k++) send_word(b2b[k], b2b[k], 1, 0, 0, -1);
    idle(20);

    // Clear mid-word
    for (int i = 0; i < 10; i++) drive(16'h1234, 16'h4321, i);
    @(negedge Dclk);
    Clear = 1'b1; Frame = 1'b0;
    repeat (3) @(negedge Dclk);
    chk_all_zero("midclr");
    Clear = 1'b0;
    send_word(16'h5A5A, 16'h0F0F, 1, 0, 0, -1);
    idle(20);

    // Frame re-asserted at bitcnt 7
    for (int i = 0; i < 7; i++) drive(16'hFFFF, 16'hFFFF, i);
    q.push_back('{l: 16'h3C3C, r: 16'hC3C3, zl: 1'b0, zr: 1'b0});
    for (int i = 0; i < 16; i++) begin
      drive(16'h3C3C, 16'hC3C3, i);
      if (i == 1) begin
        chk("ferr_pulse", {31'h0, frame_err}, 32'h1);
        chk("ferr_hold_L", {16'h0, data_L}, 32'h5A5A);
        chk("ferr_hold_R", {16'h0, data_R}, 32'h0F0F);
      end
      if (i == 2) chk("ferr_clear", {31'h0, frame_err}, 32'h0);
    end
    idle(20);

    // Zero run: flags set on the 800th zero word
    zero_det_en = 1'b1;
    for (int k = 0; k < 800; k++)
      send_word(16'h0000, 16'h0000, 1, (k == 799), (k == 799), -1);
    send_word(16'h0004, 16'h0000, 1, 0, 1, -1);
    idle(4);
    chk("zfr_held", {31'h0, zero_flag_R}, 32'h1);

    // Dropping zero_det_en clears flag and count
    zero_det_en = 1'b0;
    @(negedge Dclk);
    chk("zdis_zfr", {31'h0, zero_flag_R}, 32'h0);
    chk("zdis_zfl", {31'h0, zero_flag_L}, 32'h0);
    zero_det_en = 1'b1;
    idle(10);
    send_word(16'h0000, 16'h0000, 1, 0, 0, -1);
    idle(20);

    // InReady falls mid-word, then Frames gated off
    send_word(16'hBEEF, 16'h1357, 1, 0, 0, 5);
    for (int k = 0; k < 3; k++) send_word(16'hFFFF, 16'hFFFF, 0, 0, 0, -1);
    idle(20);
    chk("gated_L", {16'h0, data_L}, 32'hBEEF);
    chk("gated_R", {16'h0, data_R}, 32'h1357);

    chk("queue_empty", q.size(), 0);
    chk("frame_err_count", ferr_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
